// File: rtl/unrotate_seq_if.sv
// Handshake and data bundle for unrotate_seq.
// Optional SO output is present only when UNROTATE_SO_EN is defined.
//
// Handshake: the master raises start with data_in/amt/dir valid; the job is
// accepted on the first rising clk edge where start=1 and ready=1. After that,
// start and the data inputs are ignored until ready returns. done pulses for
// exactly one cycle when data_out carries the result.
interface unrotate_seq_if #(
  parameter int N = 8
);
  localparam int AW = $clog2(N);

  logic          start;
  logic [N-1:0]  data_in;
  logic [AW-1:0] amt;
  logic          dir;
  logic          ready;
  logic          busy;
  logic          done;
  logic [N-1:0]  data_out;
`ifdef UNROTATE_SO_EN
  logic          so;
`endif

  modport master (
    output start, data_in, amt, dir,
`ifdef UNROTATE_SO_EN
    input  so,
`endif
    input  ready, busy, done, data_out
  );

  modport slave (
    input  start, data_in, amt, dir,
`ifdef UNROTATE_SO_EN
    output so,
`endif
    output ready, busy, done, data_out
  );
endinterface

// File: rtl/unrotate_seq.sv
// unrotate_seq: sequential inverse of rotateN. Undoes a rotation of AMT
// positions in direction DIR (1 = right, 0 = left) by stepping the opposite
// way one bit per clock. Optional macro UNROTATE_SO_EN adds a registered SO
// output carrying the bit that wrapped in the latest step.
module unrotate_seq #(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  unrotate_seq_if.slave     bus,
  output logic [1:0]        fsm_state
);
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [N-1:0]  data_q;
  logic [AW-1:0] count_q;
  logic          dir_q;
  logic          accept;
  logic          step;

  // A job is taken only in IDLE; a step happens while count is non-zero.
  assign accept = (state_q == IDLE) && bus.start;
  assign step   = (state_q == RUN) && (count_q != '0);

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: RUN exits only once the count has been exhausted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (count_q == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the state, so they stay one-hot.
  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      IDLE:    bus.ready = 1'b1;
      RUN:     bus.busy  = 1'b1;
      FIN:     bus.done  = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  // Working register: load on accept, then step against the latched direction.
  // Original right rotation is undone with left steps (MSB wraps to LSB).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else if (accept) begin
      data_q  <= bus.data_in;
      count_q <= bus.amt;
      dir_q   <= bus.dir;
    end else if (step) begin
      if (dir_q) data_q <= {data_q[N-2:0], data_q[N-1]};
      else       data_q <= {data_q[0], data_q[N-1:1]};
      count_q <= count_q - AW'(1);
    end
  end

`ifdef UNROTATE_SO_EN
  logic so_q;

  // SO captures the wrapped bit of each step and is cleared per new job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      so_q <= 1'b0;
    else if (accept) so_q <= 1'b0;
    else if (step)   so_q <= dir_q ? data_q[N-1] : data_q[0];
  end

  assign bus.so = so_q;
`endif

  assign bus.data_out = data_q;
  assign fsm_state    = state_q;
endmodule
